// File: rtl/alu_seq.sv
// Two-cycle sequencer around an external combinational ALU, with a 4x4 register file and flags; optional carry chain under ALU_SEQ_CARRY_CHAIN_EN.
// Latency: accept at edge k, write-back and done at edge k+1; one instruction every two cycles.
// Backpressure: instr_ready is low for the single EXEC cycle; instructions offered then are not taken.
module alu_seq (
    input  logic        clk,
    input  logic        reset_n,
    input  logic        instr_valid,
    output logic        instr_ready,
    input  logic [10:0] instr,
    input  logic        ld_en,
    input  logic [1:0]  ld_addr,
    input  logic [3:0]  ld_data,
    input  logic [1:0]  rd_addr,
    output logic [3:0]  rd_data,
    output logic [3:0]  alu_a,
    output logic [3:0]  alu_b,
    output logic        alu_cin,
    output logic        alu_l,
    output logic [1:0]  alu_op,
    input  logic [3:0]  alu_r,
    input  logic        alu_zero,
    input  logic        alu_cout,
    input  logic        alu_sign,
    output logic        flag_z,
    output logic        flag_c,
    output logic        flag_s,
    output logic [3:0]  result,
    output logic        done
);

    typedef struct packed {
        logic       l;
        logic [1:0] aluop;
        logic       cin;
        logic       uc;
        logic [1:0] rd;
        logic [1:0] rs1;
        logic [1:0] rs2;
    } instr_t;

    typedef enum logic {IDLE = 1'b0, EXEC = 1'b1} state_t;

    state_t     state;
    instr_t     ins;
    logic [3:0] regs [4];
    logic [1:0] rd_q;
    logic       cin_next;

    assign ins         = instr_t'(instr);
    assign instr_ready = (state == IDLE);
    assign rd_data     = regs[rd_addr];

`ifdef ALU_SEQ_CARRY_CHAIN_EN
    // flag_c here is the value before the accept edge, i.e. from the previous write-back
    assign cin_next = ins.cin | (ins.uc & flag_c);
`else
    logic unused_uc;
    assign unused_uc = ins.uc;
    assign cin_next  = ins.cin;
`endif

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state   <= IDLE;
            alu_a   <= '0;
            alu_b   <= '0;
            alu_op  <= '0;
            alu_l   <= 1'b0;
            alu_cin <= 1'b0;
            rd_q    <= '0;
            result  <= '0;
            flag_z  <= 1'b0;
            flag_c  <= 1'b0;
            flag_s  <= 1'b0;
            done    <= 1'b0;
        end else begin
            done <= 1'b0;
            if (state == IDLE) begin
                if (instr_valid) begin
                    alu_a   <= regs[ins.rs1];
                    alu_b   <= regs[ins.rs2];
                    alu_op  <= ins.aluop;
                    alu_l   <= ins.l;
                    alu_cin <= cin_next;
                    rd_q    <= ins.rd;
                    state   <= EXEC;
                end
            end else begin
                result <= alu_r;
                flag_z <= alu_zero;
                flag_c <= alu_cout;
                flag_s <= alu_sign;
                done   <= 1'b1;
                state  <= IDLE;
            end
        end
    end

    // Write-back is issued after the external load so it takes priority on an address clash
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            for (int i = 0; i < 4; i++) regs[i] <= '0;
        end else begin
            if (ld_en) regs[ld_addr] <= ld_data;
            if (state == EXEC) regs[rd_q] <= alu_r;
        end
    end

endmodule

// File: tb/tb_alu_seq.sv
// Randomised bench for alu_seq: a transaction-level model plus directed literal scenarios.
module tb_alu_seq;

    logic        clk = 1'b0;
    logic        reset_n = 1'b1;
    logic        instr_valid = 1'b0;
    logic        instr_ready;
    logic [10:0] instr = '0;
    logic        ld_en = 1'b0;
    logic [1:0]  ld_addr = '0;
    logic [3:0]  ld_data = '0;
    logic [1:0]  rd_addr = '0;
    logic [3:0]  rd_data;
    logic [3:0]  alu_a, alu_b, alu_r;
    logic        alu_cin, alu_l, alu_zero, alu_cout, alu_sign;
    logic [1:0]  alu_op;
    logic        flag_z, flag_c, flag_s, done;
    logic [3:0]  result;

    int checks = 0;
    int failures = 0;
    logic chk_en = 1'b0;

    alu_seq dut (
        .clk(clk), .reset_n(reset_n), .instr_valid(instr_valid), .instr_ready(instr_ready),
        .instr(instr), .ld_en(ld_en), .ld_addr(ld_addr), .ld_data(ld_data),
        .rd_addr(rd_addr), .rd_data(rd_data), .alu_a(alu_a), .alu_b(alu_b),
        .alu_cin(alu_cin), .alu_l(alu_l), .alu_op(alu_op), .alu_r(alu_r),
        .alu_zero(alu_zero), .alu_cout(alu_cout), .alu_sign(alu_sign),
        .flag_z(flag_z), .flag_c(flag_c), .flag_s(flag_s), .result(result), .done(done)
    );

    always #5 clk = ~clk;

    // Reference ALU: returns {cout, r}
    function automatic logic [4:0] alu_fn(logic [3:0] a, logic [3:0] b, logic [1:0] op,
                                          logic l, logic cin);
        logic [4:0] s;
        s = '0;
        if (!l) begin
            case (op)
                2'd0: s = {1'b0, a} + {4'b0, cin};
                2'd1: s = {1'b0, a} + {1'b0, ~b} + {4'b0, cin};
                2'd2: s = {1'b0, a} + {1'b0, b} + {4'b0, cin};
                default: s = {1'b0, a} + {1'b0, a} + {4'b0, cin};
            endcase
        end else begin
            case (op)
                2'd0: s = {1'b0, a & b};
                2'd1: s = {1'b0, a | b};
                2'd2: s = {1'b0, a ^ b};
                default: s = {1'b0, ~a};
            endcase
        end
        return s;
    endfunction

    always_comb begin
        {alu_cout, alu_r} = alu_fn(alu_a, alu_b, alu_op, alu_l, alu_cin);
        alu_zero = (alu_r == 4'd0);
        alu_sign = alu_r[3];
    end

    typedef struct {
        logic [3:0] a;
        logic [3:0] b;
        logic [1:0] op;
        logic       l;
        logic       cin;
        logic [1:0] rd;
    } pend_t;

    pend_t      pend[$];
    logic [3:0] m_regs [4];
    logic [3:0] m_result, m_a, m_b;
    logic [1:0] m_op;
    logic       m_l, m_cin, m_z, m_c, m_s, m_done;

    task automatic check(string nm, logic [7:0] act, logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s actual=%h expected=%h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        pend.delete();
        for (int i = 0; i < 4; i++) m_regs[i] = '0;
        m_result = '0; m_a = '0; m_b = '0; m_op = '0;
        m_l = 0; m_cin = 0; m_z = 0; m_c = 0; m_s = 0; m_done = 0;
    endtask

    task automatic model_step();
        pend_t      p;
        logic [4:0] o;
        logic [3:0] pre [4];
        if (!reset_n) begin
            model_reset();
            return;
        end
        pre = m_regs;
        m_done = 0;
        if (ld_en) m_regs[ld_addr] = ld_data;
        if (pend.size() > 0) begin
            p = pend.pop_front();
            o = alu_fn(p.a, p.b, p.op, p.l, p.cin);
            m_regs[p.rd] = o[3:0];
            m_result = o[3:0];
            m_c = o[4];
            m_z = (o[3:0] == 4'd0);
            m_s = o[3];
            m_done = 1;
        end else if (instr_valid) begin
            p.a  = pre[instr[3:2]];
            p.b  = pre[instr[1:0]];
            p.op = instr[9:8];
            p.l  = instr[10];
`ifdef ALU_SEQ_CARRY_CHAIN_EN
            p.cin = instr[7] | (instr[6] & m_c);
`else
            p.cin = instr[7];
`endif
            p.rd = instr[5:4];
            pend.push_back(p);
            m_a = p.a; m_b = p.b; m_op = p.op; m_l = p.l; m_cin = p.cin;
        end
    endtask

    task automatic tick();
        @(posedge clk);
        model_step();
        #1;
    endtask

    always @(negedge clk) begin
        if (chk_en) begin
            check("instr_ready", instr_ready, (pend.size() == 0));
            check("done", done, m_done);
            check("result", result, m_result);
            check("flag_z", flag_z, m_z);
            check("flag_c", flag_c, m_c);
            check("flag_s", flag_s, m_s);
            check("alu_a", alu_a, m_a);
            check("alu_b", alu_b, m_b);
            check("alu_op", alu_op, m_op);
            check("alu_l", alu_l, m_l);
            check("alu_cin", alu_cin, m_cin);
            check("rd_data", rd_data, m_regs[rd_addr]);
        end
    end

    function automatic logic [10:0] mk(logic l, logic [1:0] op, logic cin, logic uc,
                                       logic [1:0] rd, logic [1:0] rs1, logic [1:0] rs2);
        return {l, op, cin, uc, rd, rs1, rs2};
    endfunction

    task automatic load(logic [1:0] a, logic [3:0] d);
        ld_en = 1; ld_addr = a; ld_data = d;
        tick();
        ld_en = 0;
    endtask

    task automatic run_instr(logic [10:0] ins);
        instr_valid = 1; instr = ins;
        tick();
        instr_valid = 0;
        tick();
    endtask

    logic [3:0] rv;
    int acc, ndone, nconsec;
    logic prev_done;

    initial begin
        model_reset();
        #1 reset_n = 0;
        #1;
        check("reset_ready", instr_ready, 1);
        check("reset_done", done, 0);
        check("reset_result", result, 0);
        chk_en = 1;
        tick();
        tick();
        reset_n = 1;

        // add R1+R2 -> R0 (5+3)
        load(2'd1, 4'h5);
        load(2'd2, 4'h3);
        rd_addr = 2'd0;
        instr_valid = 1; instr = mk(0, 2'b10, 0, 0, 2'd0, 2'd1, 2'd2);
        tick();
        instr_valid = 0;
        check("req031_no_done_at_accept", done, 0);
        tick();
        check("req031_done", done, 1);
        check("req031_r0", rd_data, 4'h8);
        check("req031_result", result, 4'h8);
        check("req031_zcs", {flag_z, flag_c, flag_s}, 3'b001);
        check("req031_model_r0", m_regs[0], 4'h8);
        tick();
        check("req031_done_one_cycle", done, 0);

        // F+1 -> R3 then carry-chain add
        load(2'd1, 4'hF);
        load(2'd2, 4'h1);
        load(2'd0, 4'h0);
        rd_addr = 2'd3;
        run_instr(mk(0, 2'b10, 0, 0, 2'd3, 2'd1, 2'd2));
        check("req032_r3", rd_data, 4'h0);
        check("req032_zcs", {flag_z, flag_c, flag_s}, 3'b110);
        rd_addr = 2'd2;
        run_instr(mk(0, 2'b10, 0, 1, 2'd2, 2'd0, 2'd0));
`ifdef ALU_SEQ_CARRY_CHAIN_EN
        check("req032_chain_r2", rd_data, 4'h1);
`else
        check("req032_chain_r2", rd_data, 4'h0);
`endif

        // valid held for four cycles
        rv = '0; acc = 0; ndone = 0; nconsec = 0; prev_done = 0;
        instr_valid = 1; instr = mk(1, 2'b10, 0, 0, 2'd1, 2'd2, 2'd3);
        for (int i = 0; i < 4; i++) begin
            rv[i] = instr_ready;
            if (instr_ready) acc++;
            tick();
            if (done) ndone++;
            if (done && prev_done) nconsec++;
            prev_done = done;
        end
        instr_valid = 0;
        for (int i = 0; i < 3; i++) begin
            tick();
            if (done) ndone++;
            if (done && prev_done) nconsec++;
            prev_done = done;
        end
        check("req033_ready_seq", rv, 4'b0101);
        check("req033_accepts", acc, 2);
        check("req033_done_pulses", ndone, 2);
        check("req033_done_width", nconsec, 0);

        // write-back beats external load on the same register
        load(2'd1, 4'h2);
        load(2'd2, 4'h4);
        rd_addr = 2'd3;
        instr_valid = 1; instr = mk(0, 2'b10, 0, 0, 2'd3, 2'd1, 2'd2);
        tick();
        instr_valid = 0;
        ld_en = 1; ld_addr = 2'd3; ld_data = 4'hA;
        tick();
        ld_en = 0;
        check("req034_r3", rd_data, 4'h6);
        tick();

        // reset during EXEC
        instr_valid = 1; instr = mk(0, 2'b10, 1, 0, 2'd0, 2'd3, 2'd3);
        tick();
        instr_valid = 0;
        #2 reset_n = 0;
        model_reset();
        #1;
        check("req035_done", done, 0);
        check("req035_flags", {flag_z, flag_c, flag_s}, 3'b000);
        check("req035_alu_a", alu_a, 4'h0);
        tick();
        check("req035_no_done", done, 0);
        reset_n = 1;
        check("req035_ready", instr_ready, 1);
        rd_addr = 2'd3;
        check("req035_r3", rd_data, 4'h0);

        // randomized traffic
        for (int i = 0; i < 600; i++) begin
            instr_valid = ($urandom_range(0, 1) == 1);
            instr       = 11'($urandom);
            ld_en       = ($urandom_range(0, 2) == 0);
            ld_addr     = 2'($urandom);
            ld_data     = 4'($urandom);
            rd_addr     = 2'($urandom);
            tick();
        end
        instr_valid = 0; ld_en = 0;
        tick();
        tick();

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/alu_seq.md
ALU_SEQ -- requirements
Module: alu_seq

Interface
REQ-001 Clocking/reset: one clock; reset is asynchronous and active-low.
REQ-002 clk  input  1  rising-edge clock.
REQ-003 reset_n  input  1  asynchronous active-low reset.
REQ-004 instr_valid  input  1  instruction offered.
REQ-005 instr_ready  output  1  instruction accepted on the edge where valid&ready=1.
REQ-006 instr  input  11  fields {l[10], aluop[9:8], cin[7], uc[6], rd[5:4], rs1[3:2], rs2[1:0]}.
REQ-007 ld_en, ld_addr, ld_data  input  1, 2, 4  external register write port.
REQ-008 rd_addr  input  2; rd_data  output  4  combinational register read for observation.
REQ-009 alu_a, alu_b  output  4 each  operands to the ALU (A, B).
REQ-010 alu_cin, alu_l  output  1 each; alu_op  output  2  ALU carry-in, logic select, ALUOP.
REQ-011 alu_r  input  4; alu_zero, alu_cout, alu_sign  input  1 each  combinational ALU results.
REQ-012 flag_z, flag_c, flag_s  output  1 each  registered flags.
REQ-013 result  output  4  last written-back value; done  output  1  write-back pulse.

Function
REQ-014 Register file: 4 x 4-bit, R0..R3, all writable; no hard-wired zero.
REQ-015 FSM: IDLE, EXEC; instr_ready = (state==IDLE).
REQ-016 IDLE + instr_valid: at edge k latch alu_a=R[rs1], alu_b=R[rs2], alu_op=aluop, alu_l=l, alu_cin (REQ-030), rd; go EXEC.
REQ-017 Operand values are pre-edge register contents (a write at edge k is not seen).
REQ-018 EXEC: the ALU settles combinationally; at edge k+1: R[rd]<=alu_r, result<=alu_r, flag_z/c/s <= alu_zero/cout/sign, done<=1, state<=IDLE.
REQ-019 done is high exactly one cycle (after edge k+1); latency accept-to-done = 2 edges; throughput 1 instr per 2 cycles.
REQ-020 instr_valid held during EXEC is ignored; the next instruction is accepted at edge k+2 at the earliest.
REQ-021 alu_a/b/op/l/cin hold their values outside EXEC (no toggling in IDLE).
REQ-022 ld_en writes R[ld_addr]<=ld_data on any edge, in any state.
REQ-023 Same edge, ld_addr==rd during write-back: write-back wins, ld discarded.
REQ-024 ld_en during EXEC to rs1/rs2 does not change the latched operands.
REQ-025 Flags change only on write-back; ld_en never alters flags.
REQ-026 rd_data = R[rd_addr], combinational, reflects writes from the next cycle onward.

Reset
REQ-027 reset_n low: state=IDLE; R0..R3=0; flags=0; result=0; done=0; alu_a=alu_b=0, alu_op=00, alu_l=0, alu_cin=0.
REQ-028 Reset asserted in EXEC aborts the instruction: no write-back, no done, no flag update.
REQ-029 First accept is possible on the first rising edge after reset_n deasserts.

Configuration
REQ-030 Macro ALU_SEQ_CARRY_CHAIN_EN. Defined: alu_cin = cin | (uc & flag_c), using flag_c as it stands at the accept edge. Undefined: alu_cin = cin, uc ignored, no carry-chain logic present.

Verification
REQ-031 Load R1=5, R2=3; instr l=0 aluop=10 cin=0 rd=0 rs1=1 rs2=2 -> done 2 edges after accept, R0=8, result=8, z=0, c=0, s=1.
REQ-032 Load R1=F, R2=1; same add, rd=3 -> R3=0, z=1, c=1, s=0; then add rd=2 rs1=0 rs2=0 (R0=0) uc=1 cin=0 -> R2=1 with macro, R2=0 without.
REQ-033 instr_valid held high 4 cycles -> instr_ready=1,0,1,0; exactly two instructions accepted; done pulses 1 cycle each.
REQ-034 Write-back to R3 with ld_en=1, ld_addr=3, ld_data=A on the same edge -> R3 = ALU result, not A.
REQ-035 reset_n pulsed low during EXEC -> no done, all registers/flags/outputs = 0, instr_ready=1 after release.
